// File: rtl/sram_host_ctrl.sv
// Host request/response front end for a single-port synchronous SRAM.
// Drives the SRAM strobe on accept and returns responses through a 2-entry in-order FIFO.
module sram_host_ctrl #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [AW+1:0]   req_addr_i,
    input  logic [3:0]      req_be_i,
    input  logic [DW-1:0]   req_wdata_i,

    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_rdata_o,
    output logic            rsp_err_o,
    output logic            rsp_we_o,

    output logic            sram_csb_o,
    output logic            sram_wenb_o,
    output logic [3:0]      sram_wmask_o,
    output logic [AW-1:0]   sram_addr_o,
    output logic [DW-1:0]   sram_wdata_o,
    input  logic [DW-1:0]   sram_rdata_i
);

    logic            req_err;
    logic            accept;
    logic            sram_go;
    logic            pop;
    logic            push;
    logic [2:0]      occupancy;
    logic [DW-1:0]   push_rdata;

    logic            pend;
    logic            pend_we;
    logic            pend_err;

    logic [DW-1:0]   fifo_rdata [2];
    logic            fifo_err   [2];
    logic            fifo_we    [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;

    always_comb begin
        req_err   = (req_addr_i[1:0] != 2'b00) || (req_we_i && (req_be_i == 4'b0000));
        occupancy = {1'b0, count} + {2'b00, pend};

        rsp_valid_o = rst_ni && (count != 2'd0);
        rsp_rdata_o = fifo_rdata[rd_ptr];
        rsp_err_o   = fifo_err[rd_ptr];
        rsp_we_o    = fifo_we[rd_ptr];
        pop         = rsp_valid_o && rsp_ready_i;

        // A pop frees a slot in the same cycle, so a full FIFO still accepts while draining.
        req_ready_o = rst_ni && ((occupancy < 3'd2) || pop);
        accept      = req_valid_i && req_ready_o;
        sram_go     = accept && !req_err;
    end

    always_comb begin
        sram_csb_o   = 1'b1;
        sram_wenb_o  = 1'b1;
        sram_wmask_o = 4'b0000;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (sram_go) begin
            sram_csb_o   = 1'b0;
            sram_wenb_o  = !req_we_i;
            sram_wmask_o = req_we_i ? req_be_i : 4'b0000;
            sram_addr_o  = req_addr_i[AW+1:2];
            sram_wdata_o = req_wdata_i;
        end
    end

    // The pending stage lines up the response with the SRAM read data, one cycle after the strobe.
    always_comb begin
        push       = pend;
        push_rdata = (!pend_err && !pend_we) ? sram_rdata_i : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend     <= 1'b0;
            pend_we  <= 1'b0;
            pend_err <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            pend     <= accept;
            pend_we  <= req_we_i;
            pend_err <= req_err;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && push) begin
            fifo_rdata[wr_ptr] <= push_rdata;
            fifo_err[wr_ptr]   <= pend_err;
            fifo_we[wr_ptr]    <= pend_we;
        end
    end

endmodule

// File: doc/sram_host_ctrl.md
SRAM_HOST_CTRL -- requirements
Module: sram_host_ctrl

Interface
REQ-001 Parameter DW, 32, data width in bits; only 32 is supported.
REQ-002 Parameter AW, 8, SRAM word-address width.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
REQ-004 clk_i  in  1  block clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  synchronous active-low reset.
REQ-006 req_valid_i  in  1  request present.
REQ-007 req_ready_o  out  1  request accepted when req_valid_i && req_ready_o ("accept").
REQ-008 req_we_i  in  1  1 = write, 0 = read.
REQ-009 req_addr_i  in  AW+2  byte address.
REQ-010 req_be_i  in  4  byte enables; bit n covers wdata[8n+7:8n].
REQ-011 req_wdata_i  in  DW  write data.
REQ-012 rsp_valid_o  out  1  response present.
REQ-013 rsp_ready_i  in  1  response consumed when rsp_valid_o && rsp_ready_i ("pop").
REQ-014 rsp_rdata_o  out  DW  read data; 0 for writes and errors.
REQ-015 rsp_err_o  out  1  request rejected.
REQ-016 rsp_we_o  out  1  echo of req_we_i for this response.
REQ-017 sram_csb_o  out  1  SRAM chip select, active low.
REQ-018 sram_wenb_o  out  1  SRAM write enable, active low.
REQ-019 sram_wmask_o  out  4  SRAM byte write mask.
REQ-020 sram_addr_o  out  AW  SRAM word address.
REQ-021 sram_wdata_o  out  DW  SRAM write data.
REQ-022 sram_rdata_i  in  DW  SRAM read data, valid the cycle after a read strobe.

Function
REQ-023 Error request: req_addr_i[1:0] != 0, or write with req_be_i == 0.
REQ-024 On accept of a non-error request, the SRAM pins are driven in the same cycle (combinational): csb=0, wenb=!req_we_i, addr=req_addr_i[AW+1:2], wdata=req_wdata_i, wmask=req_be_i for writes and 0 for reads.
REQ-025 In any cycle without a non-error accept: csb=1, wenb=1, wmask=0, addr=0, wdata=0.
REQ-026 An error request never asserts sram_csb_o low; it still produces a response with err=1, rdata=0.
REQ-027 Accepted request sets a one-entry pending stage (pend, we, err) for exactly one cycle; the next cycle pushes {rdata, err, we} into a 2-entry in-order response FIFO, with rdata = sram_rdata_i for non-error reads and 0 otherwise.
REQ-028 rsp_valid_o = FIFO non-empty; rsp_* outputs show the FIFO head; the head is removed on pop.
REQ-029 req_ready_o = rst_ni && ((fifo_count + pend) < 2 || pop).
REQ-030 Minimum latency accept -> rsp_valid_o: 2 cycles for all requests (reads, writes, errors alike).
REQ-031 With rsp_ready_i held 1, one request is accepted every cycle (full throughput).
REQ-032 Simultaneous push and pop: count unchanged, order preserved; the FIFO never overflows, and pop is ignored when empty.
REQ-033 rsp_* outputs hold stable while rsp_valid_o=1 and rsp_ready_i=0.

Reset
REQ-034 While rst_ni=0: req_ready_o=0, rsp_valid_o=0, SRAM pins in idle state per REQ-025.
REQ-035 Reset clears pend and FIFO; a read in flight at reset is discarded and never responded to.
REQ-036 First accept is possible in the first cycle with rst_ni=1.

Verification
REQ-037 Write addr 0x010, be 0xF, data 0xDEADBEEF, then read 0x010 -> SRAM sees csb=0, wenb=0, addr 0x04, wmask 0xF; read response rdata 0xDEADBEEF, err=0, 2 cycles after accept.
REQ-038 Write 0x11223344 with be 0xF, then write 0xAABBCCDD with be 0x5 to the same address, then read it -> read response 0x11BB33DD.
REQ-039 Read addr 0x013, then write with be 0x0 -> two responses, both err=1 and rdata=0; sram_csb_o stays 1 throughout.
REQ-040 Backpressure: rsp_ready_i=0 and 4 back-to-back reads offered -> exactly 2 accepted and req_ready_o=0 afterwards. Then rsp_ready_i=1 -> responses arrive in order, the remaining 2 reads are accepted, and outputs stay stable while stalled.
REQ-041 Streaming: 16 consecutive reads with rsp_ready_i=1 -> 16 accepts in 16 cycles and 16 in-order responses.
REQ-042 rst_ni=0 asserted the cycle after a read accept -> no response is ever produced; the next cycle after release has req_ready_o=1 and rsp_valid_o=0.
